write_buffer: RTL

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/wbuf_pkg.sv | 15 +
 rtl/wbuf_fifo.sv | 73 +++++++
 rtl/write_buffer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/wbuf_pkg.sv
// Shared state encoding for the write buffer FSM.
package wbuf_pkg;

  localparam int unsigned STATE_BITS = 3;

  typedef enum logic [STATE_BITS-1:0] {
    IDLE,
    RD_HIT,
    RD_MISS,
    FULL_DRAIN,
    BG_DRAIN,
    FLUSH
  } state_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Entry storage for write_buffer: circular FIFO of {addr,data} plus youngest-match search.
module wbuf_fifo #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned WORD_WIDTH = 64,
  parameter int unsigned DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [WORD_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [WORD_WIDTH-1:0] head_data,
  output logic                  full,
  output logic                  empty,
  input  logic [ADDR_WIDTH-1:0] match_addr,
  output logic                  hit,
  output logic [WORD_WIDTH-1:0] hit_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [WORD_WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH_BITS-1:0] head;
  logic [DEPTH_BITS-1:0] tail;
  logic [DEPTH_BITS:0]   count;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= push_addr;
      data_mem[tail] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full      = (count == (DEPTH_BITS+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];

  // Scan oldest to youngest so the last match found is the youngest entry.
  always_comb begin
    logic [DEPTH_BITS-1:0] idx;
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + DEPTH_BITS'(k);
      if (((DEPTH_BITS+1)'(k) < count) && (addr_mem[idx] == match_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Write buffer between cache port and main memory; FSM and port registers.
// Store-to-load forwarding is compiled in when WRITE_BUFFER_FORWARD_EN is defined.
module write_buffer
  import wbuf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned WORD_WIDTH = 64,
  parameter int unsigned DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0] dout,
  input  logic                  re,
  input  logic                  we,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [WORD_WIDTH-1:0] mout,
  input  logic [WORD_WIDTH-1:0] min,
  output logic                  mre,
  output logic                  mwe,
  input  logic                  mready
);

  state_t                state;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] laddr;
  logic [WORD_WIDTH-1:0] ldata;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [WORD_WIDTH-1:0] push_data;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [WORD_WIDTH-1:0] head_data;
  logic                  full;
  logic                  empty;
  logic                  hit;
  logic [WORD_WIDTH-1:0] hit_data;

  wbuf_fifo #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WORD_WIDTH(WORD_WIDTH),
    .DEPTH_BITS(DEPTH_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (push_addr),
    .push_data (push_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (full),
    .empty     (empty),
    .match_addr(addr),
    .hit       (hit),
    .hit_data  (hit_data)
  );

`ifndef WRITE_BUFFER_FORWARD_EN
  logic unused_hit;
  assign unused_hit = ^{hit, hit_data};
`endif

  assign ready = (state == IDLE);
  // A transfer completes once the strobe has dropped and memory reports idle again.
  assign done  = busy && mready && !mre && !mwe;

  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    push_addr = addr;
    push_data = din;
    if (state == IDLE && we && !re && !full) push = 1'b1;
    if (state == FULL_DRAIN && done) begin
      push      = 1'b1;
      pop       = 1'b1;
      push_addr = laddr;
      push_data = ldata;
    end
    if ((state == BG_DRAIN || state == FLUSH) && done) pop = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      mre   <= 1'b0;
      mwe   <= 1'b0;
      maddr <= '0;
      mout  <= '0;
      dout  <= '0;
      laddr <= '0;
      ldata <= '0;
    end else begin
      mre <= 1'b0;
      mwe <= 1'b0;
      case (state)
        IDLE: begin
          if (re) begin
            laddr <= addr;
`ifdef WRITE_BUFFER_FORWARD_EN
            if (hit) begin
              dout  <= hit_data;
              state <= RD_HIT;
            end else begin
              state <= RD_MISS;
            end
`else
            state <= empty ? RD_MISS : FLUSH;
`endif
          end else if (we) begin
            if (full) begin
              laddr <= addr;
              ldata <= din;
              state <= FULL_DRAIN;
            end
          end else if (!empty && mready) begin
            mwe   <= 1'b1;
            maddr <= head_addr;
            mout  <= head_data;
            busy  <= 1'b1;
            state <= BG_DRAIN;
          end
        end
        RD_HIT: state <= IDLE;
        RD_MISS: begin
          if (done) begin
            dout  <= min;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (!busy && mready) begin
            mre   <= 1'b1;
            maddr <= laddr;
            busy  <= 1'b1;
          end
        end
        FULL_DRAIN, BG_DRAIN, FLUSH: begin
          if (done) begin
            busy <= 1'b0;
            if (state != FLUSH) state <= IDLE;
          end else if (!busy) begin
            if (state == FLUSH && empty) begin
              state <= RD_MISS;
            end else if (mready) begin
              mwe   <= 1'b1;
              maddr <= head_addr;
              mout  <= head_data;
              busy  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
